// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one 8N1 transmitter among N_REQ byte requesters.
// req_valid->tx_start 2 clk; a requester stalls (no req_ready) until it owns an idle transmitter.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 65535,
  parameter int TMO_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 err_tmo
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             win_vld;
  logic             lock;
  logic             last_q;
  logic             low_seen;
  logic             busy_m;
  logic             busy_s;
  logic             ok_m;
  logic             ok_s;
  logic [TMO_W-1:0] tmo_cnt;

  // ok_s marks when busy_s carries a real sample rather than the reset zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
      ok_m   <= 1'b0;
      ok_s   <= 1'b0;
    end else begin
      busy_m <= tx_busy;
      busy_s <= busy_m;
      ok_m   <= 1'b1;
      ok_s   <= ok_m;
    end
  end

  always_comb begin
    winner  = rr_ptr;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        winner  = cand;
      end
    end
  end

  assign req_ready = (state == LOAD && req_valid[owner]) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      err_tmo  <= 1'b0;
      rr_ptr   <= IDX_W'(N_REQ - 1);
      owner    <= '0;
      lock     <= 1'b0;
      last_q   <= 1'b0;
      low_seen <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      err_tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (lock) begin
            if (req_valid[owner]) state <= LOAD;
          end else if (win_vld) begin
            grant  <= ONE << winner;
            owner  <= winner;
            rr_ptr <= winner;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (req_valid[owner]) begin
            tx_data  <= req_data[{owner, 3'b000} +: 8];
            last_q   <= req_last[owner];
            tx_start <= 1'b1;
            tmo_cnt  <= '0;
            low_seen <= ~busy_s & ok_s;
            state    <= WAIT_ACK;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_ACK: begin
          // an ack needs a low-to-high busy transition, so a stale busy is never taken as ours
          if (!busy_s && ok_s) low_seen <= 1'b1;
          if (busy_s && low_seen) begin
            tx_start <= 1'b0;
            state    <= WAIT_DONE;
          end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
            tx_start <= 1'b0;
            err_tmo  <= 1'b1;
            lock     <= 1'b0;
            grant    <= '0;
            state    <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!busy_s) begin
            if (last_q) begin
              lock  <= 1'b0;
              grant <= '0;
            end else begin
              lock <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, manual or modelled tx_busy,
// and a behavioural 8N1 transmitter plus line decoder for end-to-end byte ordering.
module tb_uart_tx_arbiter;

  localparam int BAUD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        err_tmo;

  logic        auto_m = 1'b0;
  logic        man_busy = 1'b0;
  logic        m_busy = 1'b0;
  logic [9:0]  m_sh = '1;
  int          m_bit = 0;
  int          m_div = 0;
  logic        ser;

  logic        r_act = 1'b0;
  int          r_cnt = 0;
  logic [7:0]  r_sh = '0;
  logic [7:0]  rx_log [64];
  int          rx_n = 0;
  int          stop_err = 0;
  int          rx_base = 0;

  logic [8:0]  rq_mem [4][16];
  int          rq_hd [4] = '{0, 0, 0, 0};
  int          rq_tl [4] = '{0, 0, 0, 0};

  logic [7:0]  exp6 [6] = '{8'h30, 8'h31, 8'h32, 8'h40, 8'h41, 8'h33};

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.N_REQ(4), .ACK_TIMEOUT(16), .TMO_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .err_tmo   (err_tmo)
  );

  always #5 clk = ~clk;

  assign tx_busy = auto_m ? m_busy : man_busy;
  assign ser     = (auto_m && m_busy) ? m_sh[0] : 1'b1;

  always @(posedge clk) begin
    if (auto_m) begin
      if (!m_busy) begin
        if (tx_start) begin
          m_sh   <= {1'b1, tx_data, 1'b0};
          m_busy <= 1'b1;
          m_bit  <= 0;
          m_div  <= 0;
        end
      end else if (m_div == BAUD - 1) begin
        m_div <= 0;
        if (m_bit == 9) m_busy <= 1'b0;
        else begin
          m_bit <= m_bit + 1;
          m_sh  <= {1'b1, m_sh[9:1]};
        end
      end else begin
        m_div <= m_div + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!r_act) begin
      if (!ser) begin
        r_act <= 1'b1;
        r_cnt <= 1;
      end
    end else begin
      r_cnt <= r_cnt + 1;
      if (r_cnt >= 5 && r_cnt <= 33 && (r_cnt % 4) == 1) r_sh <= {ser, r_sh[7:1]};
      if (r_cnt == 37) begin
        r_act        <= 1'b0;
        rx_log[rx_n] <= r_sh;
        rx_n         <= rx_n + 1;
        if (!ser) stop_err <= stop_err + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (rq_hd[i] < rq_tl[i]) begin
        req_valid[i]        = 1'b1;
        req_last[i]         = rq_mem[i][rq_hd[i]][8];
        req_data[8*i +: 8]  = rq_mem[i][rq_hd[i]][7:0];
      end else begin
        req_valid[i]        = 1'b0;
        req_last[i]         = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
      end
    end
    #1;
  endtask

  task automatic push(input int i, input logic last, input logic [7:0] d);
    rq_mem[i][rq_tl[i]] = {last, d};
    rq_tl[i]++;
  endtask

  task automatic step();
    logic [3:0] snap;
    snap = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (snap[i]) rq_hd[i]++;
    refresh();
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic expect_accept(input string tag, input int idx, input logic [7:0] d);
    int n;
    n = 0;
    while (req_ready == 4'b0 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'(1) << idx);
    chk({tag, "_grant"}, 32'(grant), 32'(1) << idx);
    step();
    chk({tag, "_start"}, 32'(tx_start), 32'(1));
    chk({tag, "_data"}, 32'(tx_data), 32'(d));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(grant == 4'b0 && tx_busy == 1'b0 && tx_start == 1'b0) && n < 600) begin
      step();
      n++;
    end
    chk(tag, 32'(grant), 32'(0));
  endtask

  initial begin
    int n;
    refresh();
    step_n(2);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_start", 32'(tx_start), 32'(0));
    chk("rst_data", 32'(tx_data), 32'(0));
    chk("rst_tmo", 32'(err_tmo), 32'(0));
    rst = 1'b0;
    step_n(2);

    // single byte, manual busy handshake
    push(0, 1'b1, 8'h55);
    refresh();
    chk("t1_pre_start", 32'(tx_start), 32'(0));
    step();
    chk("t1_ready", 32'(req_ready), 32'(1));
    chk("t1_grant", 32'(grant), 32'(1));
    chk("t1_start_lat1", 32'(tx_start), 32'(0));
    step();
    chk("t1_start", 32'(tx_start), 32'(1));
    chk("t1_data", 32'(tx_data), 32'h55);
    chk("t1_ready_off", 32'(req_ready), 32'(0));
    step_n(3);
    chk("t1_hold", 32'(tx_start), 32'(1));
    man_busy = 1'b1;
    step_n(2);
    chk("t1_sync_delay", 32'(tx_start), 32'(1));
    step();
    chk("t1_ack", 32'(tx_start), 32'(0));
    chk("t1_grant_busy", 32'(grant), 32'(1));
    man_busy = 1'b0;
    step_n(2);
    chk("t1_grant_held", 32'(grant), 32'(1));
    step();
    chk("t1_grant_rel", 32'(grant), 32'(0));

    // round-robin across all four, then req1/req3 only
    rst = 1'b1;
    step_n(2);
    rst = 1'b0;
    auto_m = 1'b1;
    push(0, 1'b1, 8'h10);
    push(1, 1'b1, 8'h11); push(1, 1'b1, 8'h21); push(1, 1'b1, 8'h31);
    push(2, 1'b1, 8'h12);
    push(3, 1'b1, 8'h13); push(3, 1'b1, 8'h23); push(3, 1'b1, 8'h33);
    refresh();
    expect_accept("t2_g0", 0, 8'h10);
    expect_accept("t2_g1", 1, 8'h11);
    expect_accept("t2_g2", 2, 8'h12);
    expect_accept("t2_g3", 3, 8'h13);
    expect_accept("t2_g1b", 1, 8'h21);
    expect_accept("t2_g3b", 3, 8'h23);
    expect_accept("t2_g1c", 1, 8'h31);
    expect_accept("t2_g3c", 3, 8'h33);

    // locked 3-byte packet from req2 while req0 waits
    push(2, 1'b0, 8'hA1); push(2, 1'b0, 8'hA2); push(2, 1'b1, 8'hA3);
    refresh();
    expect_accept("t3_a1", 2, 8'hA1);
    push(0, 1'b1, 8'h50);
    refresh();
    expect_accept("t3_a2", 2, 8'hA2);
    expect_accept("t3_a3", 2, 8'hA3);
    expect_accept("t3_r0", 0, 8'h50);
    wait_idle("t3_idle");

    // ack timeout with busy tied low
    auto_m = 1'b0;
    man_busy = 1'b0;
    push(1, 1'b1, 8'h77);
    refresh();
    expect_accept("t4", 1, 8'h77);
    step_n(15);
    chk("t4_start_hold", 32'(tx_start), 32'(1));
    chk("t4_tmo_early", 32'(err_tmo), 32'(0));
    step();
    chk("t4_start_drop", 32'(tx_start), 32'(0));
    chk("t4_tmo", 32'(err_tmo), 32'(1));
    chk("t4_grant", 32'(grant), 32'(0));
    step();
    chk("t4_tmo_pulse", 32'(err_tmo), 32'(0));
    auto_m = 1'b1;
    push(2, 1'b1, 8'h78);
    refresh();
    expect_accept("t4_next", 2, 8'h78);
    wait_idle("t4_idle");

    // reset in WAIT_DONE, then stale busy across reset release
    auto_m = 1'b0;
    man_busy = 1'b0;
    push(3, 1'b1, 8'h99);
    refresh();
    expect_accept("t5", 3, 8'h99);
    man_busy = 1'b1;
    step_n(3);
    chk("t5_wait_done", 32'(tx_start), 32'(0));
    chk("t5_grant_pre", 32'(grant), 32'(8));
    rst = 1'b1;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'(0));
    chk("t5_rst_data", 32'(tx_data), 32'(0));
    chk("t5_rst_ready", 32'(req_ready), 32'(0));
    chk("t5_rst_start", 32'(tx_start), 32'(0));
    step();
    push(0, 1'b1, 8'h5A);
    push(2, 1'b1, 8'h5B);
    refresh();
    rst = 1'b0;
    expect_accept("t5_first", 0, 8'h5A);
    step_n(5);
    chk("t5_stale_busy", 32'(tx_start), 32'(1));
    man_busy = 1'b0;
    step_n(4);
    chk("t5_low_seen", 32'(tx_start), 32'(1));
    man_busy = 1'b1;
    step_n(2);
    chk("t5_rise_sync", 32'(tx_start), 32'(1));
    step();
    chk("t5_ack", 32'(tx_start), 32'(0));
    man_busy = 1'b0;
    step_n(2);
    chk("t5_done_held", 32'(grant), 32'(1));
    step();
    chk("t5_done", 32'(grant), 32'(0));
    auto_m = 1'b1;
    expect_accept("t5_second", 2, 8'h5B);
    wait_idle("t5_idle");

    // two requesters streaming through the serial model
    rx_base = rx_n;
    push(0, 1'b0, 8'h30); push(0, 1'b0, 8'h31); push(0, 1'b1, 8'h32); push(0, 1'b1, 8'h33);
    push(1, 1'b0, 8'h40); push(1, 1'b1, 8'h41);
    refresh();
    n = 0;
    while (rx_n - rx_base < 6 && n < 3000) begin
      step();
      n++;
    end
    chk("t6_count", 32'(rx_n - rx_base), 32'(6));
    for (int k = 0; k < 6; k++) chk($sformatf("t6_byte%0d", k), 32'(rx_log[rx_base + k]), 32'(exp6[k]));
    step_n(200);
    chk("t6_no_extra", 32'(rx_n - rx_base), 32'(6));
    chk("t6_stop_bits", 32'(stop_err), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
